ln_fx: RTL and testbench

- Iterative fixed-point natural-logarithm unit; the inverse companion of the pipelined `exp` block.
- Accepts a 16-bit signed fixed-point operand (1 sign, 3 integer, 12 fractional bits) and produces ln(x) in the same format.
- Uses leading-one normalization, then shift-and-add multiplicative decomposition with a constant LUT of ln(1+2^-i).
- Sits beside `exp` in the math datapath; an `exp` → `ln_fx` chain must round-trip within tolerance.

---
 rtl/ln_fx.sv | 215 +++++++++++++++++++++
 tb/tb_ln_fx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ln_fx.sv
`timescale 1ns/1ps
// ln_fx: iterative fixed-point natural logarithm, Q3.12 in and out.
// The operand is normalised to m in [1,2) times 2^k. A greedy product of
// (1+2^-i) factors then approximates m, while the matching ln(1+2^-i)
// constants are summed. Finally k*ln2 is added, and the result is rounded
// and saturated.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   data         operand x, two's complement Q3.12, sampled on the accepting edge
//   start        request, honoured only while idle
//   output_data  ln(x), Q3.12, registered, held until the next result
//   write_enable one-cycle pulse when output_data is updated
//   busy         high while an operation is in flight
//   error        set together with write_enable when x <= 0
//
// state | meaning
// IDLE  | waiting for start, operand latched on the accepting edge
// NORM  | leading-one search, mantissa/exponent split, invalid check
// ITER  | N_ITER shift-add steps, i = 1..N_ITER
// FINAL | add k*ln2, round, saturate, register result, pulse write_enable
module ln_fx #(
   parameter int DATA_W  = 16,
   parameter int FRAC_W  = 12,
   parameter int GUARD_W = 6,
   parameter int N_ITER  = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] data,
   input  logic              start,
   output logic [DATA_W-1:0] output_data,
   output logic              write_enable,
   output logic              busy,
   output logic              error
);

   localparam int IF_W  = FRAC_W + GUARD_W;        // internal fractional bits
   localparam int M_W   = IF_W + 1;                // m, y in [1,2)
   localparam int T_W   = IF_W + 2;                // y + (y>>i) may reach 3
   localparam int ACC_W = IF_W + 1;                // sum of LUT terms stays below 1.0
   localparam int K_W   = 8;
   localparam int R_W   = IF_W + K_W + 2;
   localparam int P_W   = $clog2(DATA_W);
   localparam int SH_W  = $clog2(IF_W + 1);
   localparam int CNT_W = $clog2(N_ITER + 1);

   // Constants are built from integer power series at 2^-60 resolution, so
   // they track FRAC_W/GUARD_W without a hand-maintained table.
   function automatic longint ln1p_pow2(input int i);
      longint s;
      longint term;
      s = 0;
      for (int n = 1; n * i < 60; n++) begin
         term = (64'sd1 <<< (60 - n * i)) / longint'(n);
         if (n % 2 == 1) s = s + term;
         else            s = s - term;
      end
      return (s + (64'sd1 <<< (59 - IF_W))) >>> (60 - IF_W);
   endfunction

   // ln2 = sum over n of 2^-n / n
   function automatic longint ln2_const();
      longint s;
      s = 0;
      for (int n = 1; n < 60; n++) s = s + (64'sd1 <<< (60 - n)) / longint'(n);
      return (s + (64'sd1 <<< (59 - IF_W))) >>> (60 - IF_W);
   endfunction

   localparam longint LN2_L = ln2_const();
   localparam logic signed [R_W-1:0] LN2_C   = R_W'(LN2_L);
   localparam logic signed [R_W-1:0] HALF_C  = R_W'(2 ** (GUARD_W - 1));
   localparam logic signed [R_W-1:0] SAT_MAX = R_W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [R_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [DATA_W-1:0]     OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [M_W-1:0]        ONE_C   = {1'b1, {IF_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, NORM, ITER, FINAL} state_t;

   state_t                   state_q, state_d;
   logic [DATA_W-1:0]        opnd_q, opnd_d;
   logic [M_W-1:0]           m_q, m_d;
   logic [M_W-1:0]           y_q, y_d;
   logic [ACC_W-1:0]         acc_q, acc_d;
   logic signed [K_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]         iter_q, iter_d;
   logic                     inv_q, inv_d;
   logic [DATA_W-1:0]        out_q, out_d;
   logic                     we_q, we_d;
   logic                     err_q, err_d;

   logic [ACC_W-1:0]         lut_rom [N_ITER+1];

   assign lut_rom[0] = '0;
   for (genvar g = 1; g <= N_ITER; g++) begin : g_lut
      localparam longint LUT_C = ln1p_pow2(g);
      assign lut_rom[g] = ACC_W'(LUT_C);
   end

   // Leading-one search over the magnitude bits and mantissa alignment.
   logic [P_W-1:0]           pos;
   logic [SH_W-1:0]          shamt;
   logic [M_W-1:0]           norm_m;

   always_comb begin
      pos = '0;
      for (int b = 0; b < DATA_W - 1; b++) begin
         if (opnd_q[b]) pos = P_W'(b);
      end
      shamt  = SH_W'(IF_W) - SH_W'(pos);
      norm_m = M_W'(opnd_q[DATA_W-2:0]) << shamt;
   end

   logic [T_W-1:0]           trial;
   assign trial = {1'b0, y_q} + T_W'(y_q >> iter_q);

   // Final reconstruction: acc + k*ln2, round half up, saturate.
   logic signed [R_W-1:0]    k_ext;
   logic signed [R_W-1:0]    r_full;
   logic signed [R_W-1:0]    r_rnd;
   logic [DATA_W-1:0]        res;

   always_comb begin
      k_ext  = {{(R_W-K_W){k_q[K_W-1]}}, k_q};
      r_full = $signed({{(R_W-ACC_W){1'b0}}, acc_q}) + k_ext * LN2_C;
      r_rnd  = (r_full + HALF_C) >>> GUARD_W;
      if (inv_q)                res = OUT_MIN;
      else if (r_rnd > SAT_MAX) res = SAT_MAX[DATA_W-1:0];
      else if (r_rnd < SAT_MIN) res = OUT_MIN;
      else                      res = r_rnd[DATA_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      m_d     = m_q;
      y_d     = y_q;
      acc_d   = acc_q;
      k_d     = k_q;
      iter_d  = iter_q;
      inv_d   = inv_q;
      out_d   = out_q;
      err_d   = err_q;
      we_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opnd_d  = data;
               acc_d   = '0;
               iter_d  = '0;
               state_d = NORM;
            end
         end
         NORM: begin
            // Invalid operands still run the full schedule so latency is fixed.
            inv_d   = opnd_q[DATA_W-1] | (opnd_q == '0);
            k_d     = $signed(K_W'(pos)) - K_W'(FRAC_W);
            m_d     = norm_m;
            y_d     = ONE_C;
            iter_d  = CNT_W'(1);
            state_d = ITER;
         end
         ITER: begin
            if (trial <= {1'b0, m_q}) begin
               y_d   = trial[M_W-1:0];
               acc_d = acc_q + lut_rom[iter_q];
            end
            if (iter_q == CNT_W'(N_ITER)) state_d = FINAL;
            else                          iter_d  = iter_q + CNT_W'(1);
         end
         FINAL: begin
            out_d   = res;
            err_d   = inv_q;
            we_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         opnd_q  <= '0;
         m_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         iter_q  <= '0;
         inv_q   <= 1'b0;
         out_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         m_q     <= m_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         iter_q  <= iter_d;
         inv_q   <= inv_d;
         out_q   <= out_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign output_data  = out_q;
   assign write_enable = we_q;
   assign error        = err_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ln_fx.sv
`timescale 1ns/1ps
module tb_ln_fx;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] data = '0;
   logic        start = 1'b0;
   logic [15:0] output_data;
   logic        write_enable;
   logic        busy;
   logic        error;

   ln_fx dut (
      .CLK          (CLK),
      .RST          (RST),
      .data         (data),
      .start        (start),
      .output_data  (output_data),
      .write_enable (write_enable),
      .busy         (busy),
      .error        (error)
   );

   always #5 CLK = ~CLK;

   localparam int LAT = 14;

   typedef struct {
      logic [15:0] x;
      logic [15:0] exp_v;
      int          tol;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [15:0] exp_v;
      int          tol;
      logic        exp_err;
      int          acc_cyc;
      int          id;
   } sb_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   sb_t  sb[$];
   sb_t  it;
   vec_t vt[12];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req, input int tol);
      int d;
      total++;
      d = act - req;
      if (d < 0) d = -d;
      if (d > tol) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d tol=%0d", nm, act, req, tol);
      end
   endtask

   // Real-valued reference: round(ln(x)*4096), saturated; x <= 0 is an error.
   function automatic logic [16:0] model(input logic [15:0] x);
      real r;
      int  v;
      if (x[15] || x == 16'h0000) return {1'b1, 16'h8000};
      r = $ln(real'(x) / 4096.0) * 4096.0;
      r = $floor(r + 0.5);
      if (r < -32768.0)     v = -32768;
      else if (r > 32767.0) v = 32767;
      else                  v = int'(r);
      return {1'b0, v[15:0]};
   endfunction

   always @(negedge CLK) begin
      if (!RST && write_enable) begin
         if (sb.size() == 0) begin
            chk("spurious_we", 1, 0, 0);
         end else begin
            it = sb.pop_front();
            chk($sformatf("data[%0d]", it.id), int'($signed(output_data)), int'($signed(it.exp_v)), it.tol);
            chk($sformatf("err[%0d]", it.id), int'(error), int'(it.exp_err), 0);
            chk($sformatf("lat[%0d]", it.id), cyc - it.acc_cyc, LAT, 0);
            chk($sformatf("busy_at_we[%0d]", it.id), int'(busy), 0, 0);
         end
      end
   end

   task automatic push(input logic [15:0] ev, input int tol, input logic ee, input int id);
      sb_t s;
      s.exp_v = ev; s.tol = tol; s.exp_err = ee; s.acc_cyc = cyc; s.id = id;
      sb.push_back(s);
   endtask

   // Drives one request; data is scrambled right after the accepting edge.
   task automatic launch(input logic [15:0] x, input logic [15:0] ev, input int tol,
                         input logic ee, input int id);
      @(negedge CLK);
      data  = x;
      start = 1'b1;
      @(posedge CLK);
      #1;
      push(ev, tol, ee, id);
      @(negedge CLK);
      start = 1'b0;
      data  = 16'($urandom);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk(nm, sb.size(), 0, 0);
      sb.delete();
   endtask

   task automatic run_model(input logic [15:0] x, input int tol, input int id);
      logic [16:0] m;
      m = model(x);
      launch(x, m[15:0], tol, m[16], id);
      drain($sformatf("drain[%0d]", id));
   endtask

   initial begin
      #50000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [16:0] m;
      real         ys[6];
      int          xi;
      int          yi;

      vt[0]  = '{16'h1000, 16'h0000, 2, 1'b0};
      vt[1]  = '{16'h0800, 16'hF4E9, 2, 1'b0};
      vt[2]  = '{16'h2B7E, 16'h1000, 2, 1'b0};
      vt[3]  = '{16'h7FFF, 16'h2145, 2, 1'b0};
      vt[4]  = '{16'h0001, 16'h8000, 0, 1'b0};
      vt[5]  = '{16'h0000, 16'h8000, 0, 1'b1};
      vt[6]  = '{16'h8000, 16'h8000, 0, 1'b1};
      vt[7]  = '{16'hFFFF, 16'h8000, 0, 1'b1};
      vt[8]  = '{16'h4000, 16'h162E, 2, 1'b0};
      m = model(16'h132B); vt[9]  = '{16'h132B, m[15:0], 2, 1'b0};
      m = model(16'h0002); vt[10] = '{16'h0002, m[15:0], 2, 1'b0};
      m = model(16'h0010); vt[11] = '{16'h0010, m[15:0], 2, 1'b0};

      #1;
      chk("rst_data", int'(output_data), 0, 0);
      chk("rst_we", int'(write_enable), 0, 0);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_err", int'(error), 0, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 12; i++) begin
         launch(vt[i].x, vt[i].exp_v, vt[i].tol, vt[i].exp_err, i);
         drain($sformatf("drain_vec[%0d]", i));
      end

      // Second start while busy is ignored.
      launch(16'h1000, 16'h0000, 2, 1'b0, 100);
      repeat (3) @(negedge CLK);
      chk("busy_mid", int'(busy), 1, 0);
      data  = 16'h0100;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      drain("drain_busy");
      repeat (20) @(negedge CLK);

      // start held high: back-to-back ops 15 cycles apart, data swapped after accept.
      @(negedge CLK);
      data  = 16'h0800;
      start = 1'b1;
      @(posedge CLK);
      #1;
      push(16'hF4E9, 2, 1'b0, 101);
      @(negedge CLK);
      data = 16'h2B7E;
      repeat (15) @(posedge CLK);
      #1;
      push(16'h1000, 2, 1'b0, 102);
      @(negedge CLK);
      start = 1'b0;
      drain("drain_b2b");

      // Async reset mid-ITER, with a nonzero error/result held beforehand.
      run_model(16'h8000, 0, 103);
      @(negedge CLK);
      data  = 16'h2000;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (5) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      chk("arst_data", int'(output_data), 0, 0);
      chk("arst_we", int'(write_enable), 0, 0);
      chk("arst_busy", int'(busy), 0, 0);
      chk("arst_err", int'(error), 0, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (20) @(negedge CLK);
      run_model(16'h2000, 2, 104);

      // Sweep against the real-valued reference.
      for (int x = 16'h0010; x <= 16'h7FFF; x += 16'h0101) begin
         run_model(16'(x), 2, 200 + x / 257);
      end

      // exp -> ln round trip: quantised exp(y) must map back to y.
      ys = '{0.0, 0.3, 0.7, 1.0, 1.6, 2.0};
      for (int j = 0; j < 6; j++) begin
         xi = int'($floor($exp(ys[j]) * 4096.0 + 0.5));
         yi = int'($floor(ys[j] * 4096.0 + 0.5));
         launch(16'(xi), 16'(yi), 3, 1'b0, 400 + j);
         drain($sformatf("drain_rt[%0d]", j));
      end

      repeat (5) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
